byte_serial_add_sub: RTL and testbench

Multi-cycle N-byte adder/subtractor that sequences wide operands through one 8-bit carry-select add/sub slice, one byte per clock, least-significant byte first. It sits directly upstream of the 8-bit slice. It registers operands under a valid/ready handshake, drives the slice's A/B/cin each cycle, and captures sum/COUT. It returns the full-width result with carry-out and signed overflow under a second valid/ready handshake.

---
 rtl/byte_serial_add_sub.sv | 104 ++++++++++
 tb/tb_byte_serial_add_sub.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/byte_serial_add_sub.sv
// Multi-cycle N-byte adder/subtractor: streams operands LSB-first through one
// 8-bit carry-select slice and returns the full-width sum, carry and overflow.
module byte_serial_add_sub #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 2) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [W-1:0]  opa, opb, acc, acc_next;
  logic          carry;
  logic [IW-1:0] idx;
  logic [7:0]    sl_a, sl_b, sl_sum, sum0, sum1;
  logic          sl_cout, c0, c1, last, accept;

  // Pick the active byte and splice the slice sum into the working register.
  always_comb begin
    sl_a     = '0;
    sl_b     = '0;
    acc_next = acc;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx == IW'(k)) begin
        sl_a                = opa[8*k +: 8];
        sl_b                = opb[8*k +: 8];
        acc_next[8*k +: 8]  = sl_sum;
      end
    end
  end

  assign {c0, sum0} = {1'b0, sl_a} + {1'b0, sl_b};
  assign {c1, sum1} = {1'b0, sl_a} + {1'b0, sl_b} + 9'd1;
  assign sl_sum     = carry ? sum1 : sum0;
  assign sl_cout    = carry ? c1 : c0;

  assign last   = (idx == IW'(NBYTES - 1));
  assign accept = (state == IDLE) && in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= sub;
      idx   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_next;
      carry <= sl_cout;
      idx   <= idx + IW'(1);
      // Outputs only change once the top byte is done; the carry into bit 7
      // is recovered from sum and operand MSBs.
      if (last) begin
        result <= acc_next;
        cout   <= sl_cout;
        ovf    <= sl_sum[7] ^ sl_a[7] ^ sl_b[7] ^ sl_cout;
      end
    end
  end

endmodule

// File: tb/tb_byte_serial_add_sub.sv
// Directed bench for byte_serial_add_sub (NBYTES = 4): vector table plus
// backpressure and mid-operation reset sequences.
module tb_byte_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
  logic [31:0] a, b, result;

  int n_checks = 0;
  int n_fail   = 0;

  byte_serial_add_sub #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation, scramble inputs after accept, wait for out_valid.
  task automatic issue_wait(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                            input logic [31:0] er, input logic ec, input logic eo,
                            input string name);
    int lat;
    @(negedge clk);
    chk({name, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; a = va; b = vb; sub = vs;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; sub = ~vs;
    chk({name, " busy"}, busy, 1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, " latency"}, lat, 5);
    chk({name, " result"}, result, er);
    chk({name, " cout"}, cout, ec);
    chk({name, " ovf"}, ovf, eo);
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, " out_valid drop"}, out_valid, 0);
    chk({name, " in_ready back"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] hold_r;
    logic        hold_c, hold_o;
    logic        saw_valid;

    vecs[0] = '{32'h00000005, 32'h00000002, 1'b0, 32'h00000007, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h00000009, 32'h00000005, 1'b1, 32'h00000004, 1'b1, 1'b0};
    vecs[3] = '{32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset cout", cout, 0);
    chk("reset ovf", ovf, 0);
    chk("reset busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      issue_wait(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].c, vecs[i].o,
                 $sformatf("vec%0d", i));
      drain($sformatf("vec%0d", i));
    end

    // Backpressure: hold DONE for 3 cycles while wiggling the inputs.
    issue_wait(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, "bp");
    hold_r = result; hold_c = cout; hold_o = ovf;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      chk("bp hold result", result, 32'h80000000);
      chk("bp hold cout", cout, 0);
      chk("bp hold ovf", ovf, 1);
      chk("bp out_valid", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain("bp");
    issue_wait(32'h00000001, 32'h00000010, 1'b0, 32'h00000011, 1'b0, 1'b0, "bp next");
    drain("bp next");

    // Asynchronous reset while byte 2 is being processed.
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; sub = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst result", result, 0);
    chk("midrst cout", cout, 0);
    chk("midrst ovf", ovf, 0);
    chk("midrst busy", busy, 0);
    chk("midrst in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst no stale out_valid", saw_valid, 0);
    issue_wait(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, "post-rst");
    drain("post-rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
